// File: rtl/tdma_arbiter_if.sv
// tdma_arbiter_if: schedule controls, requester ports and forwarded output of the TDMA arbiter.
interface tdma_arbiter_if #(parameter int W = 16, parameter int TW = 16);
    logic          en;
    logic [TW-1:0] slot_len;
    logic          req0;
    logic [W-1:0]  data0;
    logic          req1;
    logic [W-1:0]  data1;
    logic          gnt0;
    logic          gnt1;
    logic          owner;
    logic [TW-1:0] slot_cnt;
    logic          out_valid;
    logic [W-1:0]  out_data;
    modport master (
        output en, slot_len, req0, data0, req1, data1,
        input  gnt0, gnt1, owner, slot_cnt, out_valid, out_data
    );
    modport slave (
        input  en, slot_len, req0, data0, req1, data1,
        output gnt0, gnt1, owner, slot_cnt, out_valid, out_data
    );
endinterface

// File: rtl/tdma_arbiter.sv
// tdma_arbiter: two-domain fixed-slot TDMA arbiter; slot timing never depends on requests.
module tdma_arbiter #(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input logic           clk,
    input logic           rst_n,
    tdma_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SLOT0, SLOT1} state_t;
    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [TW-1:0] slot_cnt_q, slot_cnt_d, len_m1;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          boundary, gnt0, gnt1;
    always_comb begin
        len_m1      = (bus.slot_len < TW'(2)) ? TW'(1) : bus.slot_len - TW'(1);
        boundary    = slot_cnt_q == '0;
        gnt0        = (state_q == SLOT0) && bus.req0 && !boundary;
        gnt1        = (state_q == SLOT1) && bus.req1 && !boundary;
        state_d     = state_q;
        owner_d     = owner_q;
        slot_cnt_d  = slot_cnt_q;
        // the boundary cycle is a dead cycle that also decides the next slot
        if (state_q == IDLE) begin
            if (bus.en) begin
                state_d    = SLOT0;
                owner_d    = 1'b0;
                slot_cnt_d = len_m1;
            end
        end else if (!boundary) begin
            slot_cnt_d = slot_cnt_q - TW'(1);
        end else if (bus.en) begin
            state_d    = (state_q == SLOT0) ? SLOT1 : SLOT0;
            owner_d    = ~owner_q;
            slot_cnt_d = len_m1;
        end else begin
            state_d    = IDLE;
            owner_d    = 1'b0;
            slot_cnt_d = '0;
        end
        out_valid_d = gnt0 | gnt1;
        out_data_d  = gnt0 ? bus.data0 : gnt1 ? bus.data1 : out_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            slot_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            slot_cnt_q  <= slot_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.owner     = owner_q;
    assign bus.slot_cnt  = slot_cnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: doc/tdma_arbiter.md
TDMA_ARBITER -- requirements
Module: tdma_arbiter

Interface
REQ-001 Parameter W, 16, requester data width.
REQ-002 Parameter TW, 16, slot length / counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scheduling enable; sampled only in IDLE and at slot boundaries.
REQ-006 slot_len  input  TW  requested slot length in cycles; sampled only at slot start.
REQ-007 req0  input  1  domain-0 request, level.
REQ-008 data0  input  W  domain-0 payload.
REQ-009 req1  input  1  domain-1 request, level.
REQ-010 data1  input  W  domain-1 payload.
REQ-011 gnt0  output  1  domain-0 grant, combinational from state and req0.
REQ-012 gnt1  output  1  domain-1 grant, combinational from state and req1.
REQ-013 owner  output  1  current slot owner (0/1), registered.
REQ-014 slot_cnt  output  TW  cycles remaining in current slot, registered.
REQ-015 out_valid  output  1  registered; payload forwarded this cycle.
REQ-016 out_data  output  W  registered forwarded payload.

Function
REQ-017 States SHALL be IDLE, SLOT0, SLOT1.
REQ-018 Effective length L SHALL be max(slot_len, 2); values 0 and 1 clamp to 2.
REQ-019 IDLE with en=1 at posedge SHALL enter SLOT0 with slot_cnt=L-1, owner=0; en=0 stays IDLE.
REQ-020 In SLOTx with slot_cnt!=0, slot_cnt SHALL decrement by 1 per cycle; state unchanged.
REQ-021 In SLOTx with slot_cnt==0 (boundary): en=1 -> other slot, slot_cnt=L-1 from current slot_len, owner toggled; en=0 -> IDLE, slot_cnt=0, owner=0.
REQ-022 Every slot SHALL last exactly L cycles; en deassertion and slot_len changes mid-slot SHALL have no effect until the boundary.
REQ-023 State, owner and slot_cnt SHALL be independent of req0, req1, data0, data1 (timing isolation).
REQ-024 gnt0 SHALL equal (state==SLOT0) && req0 && (slot_cnt!=0); gnt1 likewise for SLOT1/req1.
REQ-025 Boundary cycle (slot_cnt==0) SHALL be a dead cycle: no grant regardless of requests.
REQ-026 gnt0 and gnt1 SHALL never be high together; non-owner requests SHALL be ignored, not queued.
REQ-027 Cycle after a grant: out_valid=1, out_data=payload of the granted domain as sampled at the grant edge (latency 1).
REQ-028 Cycle after no grant: out_valid=0, out_data SHALL hold its previous value.
REQ-029 IDLE SHALL assert no grants.
REQ-030 slot_cnt arithmetic SHALL be TW-bit unsigned; no underflow occurs since decrement is gated by slot_cnt!=0.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force IDLE, owner=0, slot_cnt=0, out_valid=0, out_data=0; gnt0=gnt1=0 follow combinationally.
REQ-032 Reset asserted mid-slot SHALL abandon the slot; no partial out_valid after release.
REQ-033 After rst_n rises, first possible SLOT0 entry is the first posedge with en=1.

Verification
REQ-034 Reset, en=1, slot_len=4, no requests -> slot_cnt 3,2,1,0 owner 0, then 3,2,1,0 owner 1, repeating; no grants.
REQ-035 slot_len=4, req0=req1=1 constant, data0=0x00AA, data1=0x0055 -> gnt0 high 3 cycles, dead cycle, gnt1 high 3 cycles; out_valid pattern 1,1,1,0 per slot one cycle late, out_data 0x00AA then 0x0055.
REQ-036 slot_len=0 and slot_len=1 -> each slot lasts 2 cycles, one grant cycle each.
REQ-037 slot_len changed 4->8 mid-SLOT0, en dropped mid-SLOT1 -> SLOT0 finishes at 4, SLOT1 lasts 8, IDLE after SLOT1 boundary.
REQ-038 Two runs with identical en/slot_len but random req/data -> identical state, owner, slot_cnt traces.
REQ-039 rst_n pulsed low between clock edges at slot_cnt=2 with active grant -> outputs zero immediately, out_valid stays 0 next cycle, IDLE until en.
